simeck_round_ctrl: RTL and testbench
====================================

SIMECK_ROUND_CTRL -- requirements
Module: simeck_round_ctrl

Interface
REQ-001 Parameter DATAW, default 16, half-block width of the controlled round datapath.
REQ-002 Parameter ROUNDS, default 32, number of round iterations per block.
REQ-003 Parameter CNTW, default 6, width of round counter and key address; SHALL satisfy 2^CNTW > ROUNDS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to process one block; sampled only in IDLE.
REQ-007 mode  input  1  0 = encrypt (keys ascending), 1 = decrypt (keys descending); latched with accepted start.
REQ-008 abort  input  1  synchronous cancel; present only when SIMECK_ABORT_EN defined.
REQ-009 dctr  output  1  datapath load select: 1 = load external half-word, 0 = feed back round output.
REQ-010 half_sel  output  1  selects which input half-word is driven onto the datapath data bus (0 = first half, 1 = second half).
REQ-011 key_addr  output  CNTW  round-key memory address; memory returns key combinationally on C.
REQ-012 round_idx  output  CNTW  current round number, 0..ROUNDS-1 during RUN.
REQ-013 busy  output  1  high in LOAD0, LOAD1, RUN.
REQ-014 done  output  1  one-cycle pulse; datapath registers hold the result during this cycle.

Function
REQ-015 FSM states SHALL be IDLE, LOAD0, LOAD1, RUN, DONE; all outputs registered or decoded from state and counter only.
REQ-016 IDLE: dctr=0, busy=0, done=0; start=1 at a rising edge -> LOAD0, mode latched; start=0 -> stay.
REQ-017 LOAD0: dctr=1, half_sel=0; unconditional -> LOAD1.
REQ-018 LOAD1: dctr=1, half_sel=1; unconditional -> RUN with round counter cleared to 0.
REQ-019 RUN: dctr=0, half_sel=0; round counter increments each cycle; at counter = ROUNDS-1 -> DONE and counter cleared to 0.
REQ-020 key_addr SHALL equal counter when latched mode=0 and ROUNDS-1-counter when latched mode=1, in every RUN cycle; key_addr SHALL be 0 outside RUN.
REQ-021 round_idx SHALL equal counter in RUN and 0 elsewhere.
REQ-022 DONE: done=1, busy=0, dctr=0; unconditional -> IDLE; start in DONE SHALL be ignored.
REQ-023 Latency: start accepted at edge E -> RUN occupies cycles E+3..E+ROUNDS+2, done high for exactly cycle E+ROUNDS+3 (cycle 35 for ROUNDS=32).
REQ-024 start asserted while busy or in DONE SHALL be ignored, not queued; mode changes while busy SHALL have no effect.
REQ-025 Back-to-back: start held high continuously SHALL yield one block per ROUNDS+4 cycles.
REQ-026 Counter arithmetic is unsigned CNTW-bit; it SHALL never exceed ROUNDS-1.

Reset
REQ-027 reset low SHALL immediately force state IDLE, counter 0, latched mode 0, independent of clk.
REQ-028 Reset values: dctr=0, half_sel=0, key_addr=0, round_idx=0, busy=0, done=0.
REQ-029 reset asserted mid-RUN SHALL discard the block with no done pulse; first start after release SHALL be sampled at the first rising edge with reset high.

Configuration
REQ-030 Macro SIMECK_ABORT_EN: when defined, abort=1 in LOAD0, LOAD1 or RUN SHALL return to IDLE at the next edge, clear counter, suppress done; abort in IDLE/DONE has no effect; abort with start in IDLE -> start wins.
REQ-031 Without SIMECK_ABORT_EN the abort port SHALL not exist and every accepted block SHALL run to DONE.

Verification
REQ-032 reset low then high, start=0 for 10 cycles -> all outputs 0, state IDLE throughout.
REQ-033 ROUNDS=32, mode=0, start pulse at edge 0 -> dctr=1 cycles 1-2, half_sel 0 then 1, key_addr 0..31 cycles 3-34, done=1 only cycle 35.
REQ-034 mode=1, start pulse -> key_addr 31 down to 0 over RUN; toggling mode mid-RUN leaves sequence unchanged.
REQ-035 start held high for 80 cycles -> done pulses at cycles 35 and 71, start pulses during busy ignored.
REQ-036 reset driven low asynchronously at round_idx=10 -> outputs zero before next edge, no done; new start after release -> full 32-round sequence.
REQ-037 With SIMECK_ABORT_EN, abort=1 at round_idx=5 -> IDLE next cycle, busy=0, no done; abort in IDLE with start=1 -> block accepted normally.

Source files
------------

// File: rtl/simeck_round_ctrl.sv
// simeck_round_ctrl: sequences one Simeck block through load, ROUNDS iterations and done.
// Optional synchronous abort port is compiled in when SIMECK_ABORT_EN is defined.
module simeck_round_ctrl #(
    parameter int DATAW  = 16,
    parameter int ROUNDS = 32,
    parameter int CNTW   = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
`ifdef SIMECK_ABORT_EN
    input  logic            abort,
`endif
    output logic            dctr,
    output logic            half_sel,
    output logic [CNTW-1:0] key_addr,
    output logic [CNTW-1:0] round_idx,
    output logic            busy,
    output logic            done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD0 = 3'd1;
    localparam logic [2:0] LOAD1 = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [CNTW-1:0] LAST = CNTW'(ROUNDS - 1);

    if (DATAW < 1 || ROUNDS < 1 || (1 << CNTW) <= ROUNDS) begin : g_bad_cfg
        $error("simeck_round_ctrl: counter too narrow for ROUNDS or bad DATAW");
    end

    logic [2:0]      state;
    logic [CNTW-1:0] cnt;
    logic            mode_q;
    logic            kill;
    logic            run;

`ifdef SIMECK_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    // State, round counter and mode latched at block acceptance; abort only acts while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD0;
                    mode_q <= mode;
                end
                LOAD0: state <= kill ? IDLE : LOAD1;
                LOAD1: begin
                    state <= kill ? IDLE : RUN;
                    cnt   <= '0;
                end
                RUN: if (kill || cnt == LAST) begin
                    state <= kill ? IDLE : DONE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of state, counter and latched mode, so reset clears them at once.
    always_comb begin
        run       = state == RUN;
        dctr      = state == LOAD0 || state == LOAD1;
        half_sel  = state == LOAD1;
        busy      = dctr || run;
        done      = state == DONE;
        round_idx = run ? cnt : '0;
        key_addr  = run ? (mode_q ? LAST - cnt : cnt) : '0;
    end
endmodule

// File: tb/tb_simeck_round_ctrl.sv
// tb_simeck_round_ctrl: table vectors, directed corner sequences and random traffic vs a cycle-count model.
module tb_simeck_round_ctrl;
    localparam int R = 32;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset, start, mode;
    logic         dctr, half_sel, busy, done;
    logic [W-1:0] key_addr, round_idx;
`ifdef SIMECK_ABORT_EN
    logic         abort;
`endif

    simeck_round_ctrl #(.DATAW(16), .ROUNDS(R), .CNTW(W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef SIMECK_ABORT_EN
        .abort(abort),
`endif
        .dctr(dctr), .half_sel(half_sel), .key_addr(key_addr),
        .round_idx(round_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_asrt++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: t = cycles elapsed since the accepting edge (-1 when idle), mm = mode captured then.
    int   t  = -1;
    logic mm = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t  <= -1;
            mm <= 1'b0;
        end else if (t < 0) begin
            if (start) begin
                t  <= 1;
                mm <= mode;
            end
        end else if (t == R + 3) t <= -1;
`ifdef SIMECK_ABORT_EN
        else if (abort) t <= -1;
`endif
        else t <= t + 1;
    end

    function automatic logic [2*W+3:0] expv(int tt, logic m);
        logic         run = tt >= 3 && tt <= R + 2;
        int           r   = tt - 3;
        logic [W-1:0] ri  = run ? W'(r) : '0;
        logic [W-1:0] ka  = run ? W'(m ? R - 1 - r : r) : '0;
        return {tt == 1 || tt == 2, tt == 2, ka, ri, tt >= 1 && tt <= R + 2, tt == R + 3};
    endfunction

    always @(negedge clk)
        chk("model", {dctr, half_sel, key_addr, round_idx, busy, done}, expv(t, mm));

    typedef struct {
        int   cyc;
        logic dctr, hs, busy, done;
        int   ka, ri;
    } vec_t;

    vec_t tbl[9];
    int   q[$];

    task automatic wait_ridx(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && !dctr && round_idx == W'(v)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        int runs;
        tbl[0] = '{1,  1, 0, 1, 0, 0,  0};
        tbl[1] = '{2,  1, 1, 1, 0, 0,  0};
        tbl[2] = '{3,  0, 0, 1, 0, 0,  0};
        tbl[3] = '{4,  0, 0, 1, 0, 1,  1};
        tbl[4] = '{20, 0, 0, 1, 0, 17, 17};
        tbl[5] = '{34, 0, 0, 1, 0, 31, 31};
        tbl[6] = '{35, 0, 0, 0, 1, 0,  0};
        tbl[7] = '{36, 0, 0, 0, 0, 0,  0};
        tbl[8] = '{33, 0, 0, 1, 0, 30, 30};
        reset = 1'b0; start = 1'b0; mode = 1'b0;
`ifdef SIMECK_ABORT_EN
        abort = 1'b0;
`endif
        @(negedge clk);
        reset = 1'b1;
        // Idle after reset: everything stays zero.
        repeat (10) begin
            @(negedge clk);
            chk("idle_outs", {dctr, half_sel, key_addr, round_idx, busy, done}, 0);
        end
        // Encrypt block against fixed checkpoints.
        start = 1'b1; mode = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            start = 1'b0;
            foreach (tbl[i]) if (tbl[i].cyc == c) begin
                chk("tbl_dctr", dctr, tbl[i].dctr);
                chk("tbl_half_sel", half_sel, tbl[i].hs);
                chk("tbl_busy", busy, tbl[i].busy);
                chk("tbl_done", done, tbl[i].done);
                chk("tbl_key_addr", key_addr, tbl[i].ka);
                chk("tbl_round_idx", round_idx, tbl[i].ri);
            end
        end
        // Decrypt with mode toggling during the block.
        start = 1'b1; mode = 1'b1;
        q = {};
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && !dctr) q.push_back(int'(key_addr));
            mode = ~mode;
        end
        chk("dec_len", q.size(), R);
        foreach (q[i]) chk("dec_key_addr", q[i], R - 1 - i);
        // Start held high: one block every ROUNDS+4 cycles.
        start = 1'b1; mode = 1'b0;
        q = {};
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done) q.push_back(c);
        end
        start = 1'b0;
        chk("held_done_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("held_done_first", q[0], 35);
            chk("held_done_second", q[1], 71);
        end
        repeat (40) @(negedge clk);
        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ridx(10, ok);
        chk("wait_ridx10", ok, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_key_addr", key_addr, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        reset = 1'b1; start = 1'b1;
        runs = 0;
        q = {};
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && !dctr) runs++;
            if (done) q.push_back(c);
        end
        chk("post_rst_runs", runs, R);
        chk("post_rst_done", q.size() == 1 && q[0] == 35, 1);
`ifdef SIMECK_ABORT_EN
        // Abort mid-RUN, then abort colliding with start in IDLE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ridx(5, ok);
        chk("wait_ridx5", ok, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_idle_busy", busy, 1);
        chk("abort_idle_dctr", dctr, 1);
        repeat (40) @(negedge clk);
`endif
        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 7) == 0;
            mode  = 1'($urandom_range(0, 1));
`ifdef SIMECK_ABORT_EN
            abort = $urandom_range(0, 63) == 0;
`endif
        end
        start = 1'b0;
`ifdef SIMECK_ABORT_EN
        abort = 1'b0;
`endif
        repeat (40) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
